// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone adder.
// master drives operands and out_ready; slave is the adder.
interface ksa_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// One operand register, then a register after every REG_EVERY prefix levels.
module ksa_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 2
) (
    input logic       clk,
    input logic       rst_n,
    ksa_pipe_if.slave bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned NSTG   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
    localparam int unsigned SIW    = (NSTG > 1) ? $clog2(NSTG) : 1;
    localparam int unsigned BW     = $clog2(WIDTH + 1);

    // Prefix vectors are WIDTH+1 wide: bit 0 holds c0 as a generate at position -1.
    logic [NSTG-1:0][WIDTH:0]   g_q, g_d;
    logic [NSTG-1:0][WIDTH:0]   pg_q, pg_d;
    logic [NSTG-1:0][WIDTH-1:0] x_q, x_d;
    logic [NSTG:0]              vld_q, vld_d;
    logic [WIDTH-1:0]           sum_q, sum_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;
    logic                       stall;

    assign stall         = vld_q[NSTG] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld_q[NSTG];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   cur_g, cur_p, nxt_g, nxt_p;

        g_d   = '0;
        pg_d  = '0;
        x_d   = '0;
        cur_g = '0;
        cur_p = '0;
        nxt_g = '0;
        nxt_p = '0;

        b_eff   = bus.sub ? ~bus.b : bus.b;
        vld_d   = {vld_q[NSTG-1:0], bus.in_valid};
        g_d[0]  = {bus.a & b_eff, bus.sub | bus.cin};
        pg_d[0] = {bus.a ^ b_eff, 1'b0};
        x_d[0]  = bus.a ^ b_eff;

        // Level k reads its stage register when it starts a stage, else the previous level.
        for (int unsigned k = 0; k < LEVELS; k++) begin
            if (k % REG_EVERY == 0) begin
                cur_g = g_q[SIW'(k / REG_EVERY)];
                cur_p = pg_q[SIW'(k / REG_EVERY)];
            end
            nxt_g = cur_g;
            nxt_p = cur_p;
            for (int unsigned j = 0; j <= WIDTH; j++) begin
                if (j >= (32'd1 << k)) begin
                    nxt_g[BW'(j)] = cur_g[BW'(j)] | (cur_p[BW'(j)] & cur_g[BW'(j - (32'd1 << k))]);
                    nxt_p[BW'(j)] = cur_p[BW'(j)] & cur_p[BW'(j - (32'd1 << k))];
                end
            end
            cur_g = nxt_g;
            cur_p = nxt_p;
            if (((k + 1) % REG_EVERY == 0) && (k + 1 < LEVELS)) begin
                g_d[SIW'((k + 1) / REG_EVERY)]  = cur_g;
                pg_d[SIW'((k + 1) / REG_EVERY)] = cur_p;
                x_d[SIW'((k + 1) / REG_EVERY)]  = x_q[SIW'(k / REG_EVERY)];
            end
        end

        // cur_g[i] is the carry into bit i; the top group spans bits 1..WIDTH and
        // still needs one combine with the c0 slot to give the carry out.
        sum_d  = x_q[NSTG-1] ^ cur_g[WIDTH-1:0];
        cout_d = cur_g[WIDTH] | (cur_p[WIDTH] & cur_g[0]);
        ovf_d  = cout_d ^ cur_g[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= '0;
            pg_q   <= '0;
            x_q    <= '0;
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!stall) begin
            g_q    <= g_d;
            pg_q   <= pg_d;
            x_q    <= x_d;
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_ksa_pipe.sv
// Directed and streaming checks for ksa_pipe, plus a width/REG_EVERY sweep
// of extra instances driven in lockstep.
module tb_ksa_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ksa_pipe_if #(.WIDTH(32)) bus_if ();
    ksa_pipe #(.WIDTH(32), .REG_EVERY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    function automatic int unsigned cfg_w(input int unsigned c);
        case (c)
            0, 1:    return 8;
            2, 3:    return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int unsigned cfg_re(input int unsigned c);
        case (c)
            0, 2, 4: return 1;
            1:       return 3;
            3:       return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int unsigned cfg_lat(input int unsigned c);
        case (c)
            0:       return 4;
            1:       return 2;
            2:       return 5;
            3:       return 2;
            4:       return 7;
            default: return 2;
        endcase
    endfunction

    logic [63:0]      sw_a, sw_b;
    logic             sw_cin, sw_sub, sw_in_valid, sw_out_ready;
    logic [5:0][63:0] sw_sum;
    logic [5:0]       sw_ov, sw_co, sw_of, sw_ir;

    for (genvar c = 0; c < 6; c++) begin : g_sw
        localparam int unsigned CW = cfg_w(c);
        localparam int unsigned CR = cfg_re(c);
        ksa_pipe_if #(.WIDTH(CW)) sif ();
        assign sif.in_valid  = sw_in_valid;
        assign sif.a         = sw_a[CW-1:0];
        assign sif.b         = sw_b[CW-1:0];
        assign sif.cin       = sw_cin;
        assign sif.sub       = sw_sub;
        assign sif.out_ready = sw_out_ready;
        assign sw_ov[c]      = sif.out_valid;
        assign sw_sum[c]     = 64'(sif.sum);
        assign sw_co[c]      = sif.cout;
        assign sw_of[c]      = sif.ovf;
        assign sw_ir[c]      = sif.in_ready;
        ksa_pipe #(.WIDTH(CW), .REG_EVERY(CR)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sif));
    end

    // Reference: {ovf, cout, sum} from plain integer arithmetic at width w.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub,
                                          input int unsigned w);
        logic [63:0] m, am, bm;
        logic [64:0] full;
        logic        co, cm;
        m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & m;
        bm   = (sub ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, bm} + 65'(sub ? 1'b1 : cin);
        co   = full[w];
        cm   = full[w-1] ^ am[w-1] ^ bm[w-1];
        return {cm ^ co, co, full[63:0] & m};
    endfunction

    logic [63:0] st_a [128];
    logic [63:0] st_b [128];
    logic        st_cin [128];
    logic        st_sub [128];

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            st_a[i]   = {$urandom, $urandom};
            st_b[i]   = {$urandom, $urandom};
            st_cin[i] = 1'($urandom_range(0, 1));
            st_sub[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        bus_if.in_valid  = 1'b1;
        bus_if.a         = 32'hDEADBEEF;
        bus_if.b         = 32'h12345678;
        bus_if.cin       = 1'b1;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus_if.out_valid, bus_if.sum, bus_if.cout, bus_if.ovf, bus_if.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got ov=%b sum=%h c=%b o=%b ir=%b want ov=0 sum=0 c=0 o=0 ir=1",
                     bus_if.out_valid, bus_if.sum, bus_if.cout, bus_if.ovf, bus_if.in_ready);
        end
        checks++;
        if ({sw_ov, sw_ir} !== {6'b000000, 6'b111111}) begin
            errors++;
            $display("FAIL reset_sweep got ov=%b ir=%b want ov=000000 ir=111111", sw_ov, sw_ir);
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [7] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000005,
                                32'h00000003, 32'h12345678, 32'h00000010};
        logic [31:0] vb [7] = '{32'h00000001, 32'h00000001, 32'h00000000, 32'h00000003,
                                32'h00000005, 32'h9ABCDEF0, 32'h00000010};
        logic        vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] es [7] = '{32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000002,
                                32'hFFFFFFFE, 32'hACF13569, 32'h00000000};
        logic        ec [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        bit found;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus_if.in_valid  = 1'b1;
            bus_if.a         = va[i];
            bus_if.b         = vb[i];
            bus_if.cin       = vc[i];
            bus_if.sub       = vs[i];
            bus_if.out_ready = 1'b1;
            lat   = 0;
            found = 1'b0;
            repeat (20) begin
                @(negedge clk);
                bus_if.in_valid = 1'b0;
                lat++;
                #1;
                if (bus_if.out_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found || lat != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d (found=%b) want 4", i, lat, found);
            end
            checks++;
            if ({bus_if.sum, bus_if.cout, bus_if.ovf} !== {es[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                         i, bus_if.sum, bus_if.cout, bus_if.ovf, es[i], ec[i], eo[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int in_idx = 0, out_idx = 0, cyc = 0, first_cyc = -1, last_cyc = -1, extra = 0;
        logic [65:0] exp;
        fill_random(100);
        while (out_idx < 100 && cyc < 400) begin
            @(negedge clk);
            bus_if.out_ready = 1'b1;
            bus_if.in_valid  = (in_idx < 100);
            bus_if.a         = st_a[in_idx % 100][31:0];
            bus_if.b         = st_b[in_idx % 100][31:0];
            bus_if.cin       = st_cin[in_idx % 100];
            bus_if.sub       = st_sub[in_idx % 100];
            #1;
            if (bus_if.out_valid) begin
                exp = model(st_a[out_idx], st_b[out_idx], st_cin[out_idx], st_sub[out_idx], 32);
                checks++;
                if ({bus_if.sum, bus_if.cout, bus_if.ovf} !== {exp[31:0], exp[64], exp[65]}) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                             out_idx, bus_if.sum, bus_if.cout, bus_if.ovf, exp[31:0], exp[64], exp[65]);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                out_idx++;
            end
            if (bus_if.in_valid && bus_if.in_ready) in_idx++;
            cyc++;
        end
        bus_if.in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus_if.out_valid) extra++;
        end
        checks++;
        if (out_idx != 100 || extra != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d (+%0d extra) want 100", out_idx, extra);
        end
        checks++;
        if (first_cyc != 4 || last_cyc - first_cyc != 99) begin
            errors++;
            $display("FAIL b2b_rate got first=%0d span=%0d want first=4 span=99", first_cyc, last_cyc - first_cyc);
        end
    endtask

    task automatic test_backpressure();
        int in_idx = 0, out_idx = 0, cyc = 0, extra = 0;
        logic [31:0] held = '0;
        logic [65:0] exp;
        fill_random(20);
        while (out_idx < 20 && cyc < 200) begin
            @(negedge clk);
            bus_if.out_ready = !(cyc >= 8 && cyc < 14);
            bus_if.in_valid  = (in_idx < 20);
            bus_if.a         = st_a[in_idx % 20][31:0];
            bus_if.b         = st_b[in_idx % 20][31:0];
            bus_if.cin       = st_cin[in_idx % 20];
            bus_if.sub       = st_sub[in_idx % 20];
            #1;
            if (cyc == 8) begin
                held = bus_if.sum;
                checks++;
                if ({bus_if.out_valid, bus_if.in_ready, bus_if.in_valid} !== 3'b101) begin
                    errors++;
                    $display("FAIL bp_stall_entry got ov=%b ir=%b iv=%b want ov=1 ir=0 iv=1",
                             bus_if.out_valid, bus_if.in_ready, bus_if.in_valid);
                end
            end else if (cyc > 8 && cyc < 14) begin
                checks++;
                if ({bus_if.out_valid, bus_if.in_ready, bus_if.sum} !== {1'b1, 1'b0, held}) begin
                    errors++;
                    $display("FAIL bp_hold[%0d] got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h",
                             cyc, bus_if.out_valid, bus_if.in_ready, bus_if.sum, held);
                end
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                exp = model(st_a[out_idx], st_b[out_idx], st_cin[out_idx], st_sub[out_idx], 32);
                checks++;
                if ({bus_if.sum, bus_if.cout, bus_if.ovf} !== {exp[31:0], exp[64], exp[65]}) begin
                    errors++;
                    $display("FAIL bp_result[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                             out_idx, bus_if.sum, bus_if.cout, bus_if.ovf, exp[31:0], exp[64], exp[65]);
                end
                out_idx++;
            end
            if (bus_if.in_valid && bus_if.in_ready) in_idx++;
            cyc++;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus_if.out_valid) extra++;
        end
        checks++;
        if (out_idx != 20 || extra != 0) begin
            errors++;
            $display("FAIL bp_count got %0d (+%0d extra) want 20", out_idx, extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ra [3] = '{32'h11111111, 32'h00000100, 32'h0F0F0F0F};
        logic [31:0] rb [3] = '{32'h22222222, 32'h00000001, 32'h01010101};
        logic        rs [3] = '{1'b0, 1'b1, 1'b0};
        int lat = 0, stale = 0;
        bit found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.in_valid  = 1'b1;
            bus_if.a         = ra[i];
            bus_if.b         = rb[i];
            bus_if.cin       = 1'b0;
            bus_if.sub       = rs[i];
            bus_if.out_ready = 1'b0;
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus_if.out_valid, bus_if.sum} !== {1'b1, 32'h33333333}) begin
            errors++;
            $display("FAIL rstmid_pre got ov=%b sum=%h want ov=1 sum=33333333", bus_if.out_valid, bus_if.sum);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.out_valid, bus_if.sum, bus_if.cout, bus_if.ovf, bus_if.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async got ov=%b sum=%h c=%b o=%b ir=%b want ov=0 sum=0 c=0 o=0 ir=1",
                     bus_if.out_valid, bus_if.sum, bus_if.cout, bus_if.ovf, bus_if.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n            = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.a         = 32'h0000000A;
        bus_if.b         = 32'h00000003;
        bus_if.cin       = 1'b0;
        bus_if.sub       = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 1", bus_if.in_ready);
        end
        repeat (20) begin
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            lat++;
            #1;
            if (bus_if.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || lat != 4 || {bus_if.sum, bus_if.cout, bus_if.ovf} !== {32'h00000007, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_first got lat=%0d sum=%h c=%b o=%b want lat=4 sum=00000007 c=1 o=0",
                     lat, bus_if.sum, bus_if.cout, bus_if.ovf);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus_if.out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rstmid_stale got %0d stale beats want 0", stale);
        end
    endtask

    task automatic test_param_sweep();
        int oidx [6] = '{0, 0, 0, 0, 0, 0};
        logic [65:0] exp;
        fill_random(30);
        sw_out_ready = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            sw_in_valid = (cyc < 30);
            sw_a        = st_a[cyc % 30];
            sw_b        = st_b[cyc % 30];
            sw_cin      = st_cin[cyc % 30];
            sw_sub      = st_sub[cyc % 30];
            #1;
            if (cyc < 30) begin
                checks++;
                if (sw_ir !== 6'b111111) begin
                    errors++;
                    $display("FAIL sweep_ready[%0d] got %b want 111111", cyc, sw_ir);
                end
            end
            for (int c = 0; c < 6; c++) begin
                if (sw_ov[c] && oidx[c] < 30) begin
                    exp = model(st_a[oidx[c]], st_b[oidx[c]], st_cin[oidx[c]], st_sub[oidx[c]], cfg_w(c));
                    checks++;
                    if ({sw_sum[c], sw_co[c], sw_of[c]} !== {exp[63:0], exp[64], exp[65]}) begin
                        errors++;
                        $display("FAIL sweep_result[cfg%0d][%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                                 c, oidx[c], sw_sum[c], sw_co[c], sw_of[c], exp[63:0], exp[64], exp[65]);
                    end
                    if (oidx[c] == 0) begin
                        checks++;
                        if (cyc != int'(cfg_lat(c))) begin
                            errors++;
                            $display("FAIL sweep_latency[cfg%0d] got %0d want %0d", c, cyc, cfg_lat(c));
                        end
                    end
                    oidx[c]++;
                end else if (sw_ov[c]) begin
                    oidx[c]++;
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (oidx[c] != 30) begin
                errors++;
                $display("FAIL sweep_count[cfg%0d] got %0d want 30", c, oidx[c]);
            end
        end
        sw_in_valid = 1'b0;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b1;
        sw_a             = '0;
        sw_b             = '0;
        sw_cin           = 1'b0;
        sw_sub           = 1'b0;
        sw_in_valid      = 1'b0;
        sw_out_ready     = 1'b1;

        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
